// File: rtl/pmu_pkg.sv
// Shared PMU constants: PISO and SIPO stages take their word width from one place.
package pmu_pkg;

  localparam int unsigned PISO_WIDTH = 128;
  localparam int unsigned SIPO_WIDTH = PISO_WIDTH;

  // Bit-counter width for a word of the given size.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sipo_collector.sv
// Serial-in/parallel-out collector: assembles MSB-first bits into WIDTH-bit words
// behind a valid/ready holding register. Optional macro: SIPO_OVERFLOW_EN.
module sipo_collector
  import pmu_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             data_i,
  input  logic             flush,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shift_next;

  // A bit presented together with flush is discarded.
  assign w_accept     = en & ~flush;
  assign w_last       = w_accept & (r_cnt == CNT_W'(WIDTH - 1));
  assign w_xfer       = r_valid & ready_i;
  assign w_shift_next = {r_shift[WIDTH-2:0], data_i};

  // Bit counter and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (flush) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (en) begin
      r_shift <= w_shift_next;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

`ifdef SIPO_OVERFLOW_EN
  logic r_ovf;

  // Holding register: a completed word is dropped while an old one is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_last && (!r_valid || ready_i)) begin
      r_data  <= w_shift_next;
      r_valid <= 1'b1;
    end else if (w_last) begin
      r_ovf   <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign overflow_o = r_ovf;
`else
  // Holding register: a completed word always replaces the held one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_last) begin
      r_data  <= w_shift_next;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign overflow_o = 1'b0;
`endif

  assign data_o  = r_data;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector: table of single words plus multi-cycle
// sequences (back-to-back, backpressure, flush, mid-word reset, coincident edge).
module tb_sipo_collector;

  localparam int unsigned W = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         data_i;
  logic         flush;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         overflow_o;

  int checks = 0;
  int errors = 0;

  localparam logic [W-1:0] WORD_A = 128'habcdef0123456789abcdef0123456789;
  localparam logic [W-1:0] WORD_B = 128'h9876543210fedcba9876543210fedcba;

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp_data;
    int           exp_pulses;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sipo_collector #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data_i     (data_i),
    .flush      (flush),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .overflow_o (overflow_o)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    en     = 1'b1;
    data_i = b;
    tick();
  endtask

  // Streams one word MSB first; counts valid_o cycles seen after each bit.
  task automatic send_word(input logic [W-1:0] w, output int pulses, output logic [W-1:0] seen);
    pulses = 0;
    seen   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (valid_o) begin
        pulses++;
        seen = data_o;
      end
    end
  endtask

  task automatic idle();
    en     = 1'b0;
    data_i = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    en     = 1'b0;
    data_i = 1'b0;
    flush  = 1'b0;
    rst    = 1'b0;
    #1;
    check("reset valid_o", W'(valid_o), W'(0));
    check("reset data_o", data_o, W'(0));
    check("reset overflow_o", W'(overflow_o), W'(0));
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int           pulses;
    logic [W-1:0] seen;
    logic [W-1:0] wa;
    logic [W-1:0] wb;
    logic [W-1:0] da;
    logic [W-1:0] db;
    int           p0;
    int           p1;
    int           np;
    logic         b;

    rst     = 1'b0;
    en      = 1'b0;
    data_i  = 1'b0;
    flush   = 1'b0;
    ready_i = 1'b1;

    vecs[0] = '{WORD_A, 128'habcdef0123456789abcdef0123456789, 1};
    vecs[1] = '{{W{1'b1}}, 128'hffffffffffffffffffffffffffffffff, 1};
    vecs[2] = '{W'(0), 128'h0, 1};
    vecs[3] = '{W'(1), 128'h00000000000000000000000000000001, 1};
    vecs[4] = '{{1'b1, {(W-1){1'b0}}}, 128'h80000000000000000000000000000000, 1};

    // Single words with ready_i=1: one-cycle valid_o pulse after the last bit.
    do_reset();
    ready_i = 1'b1;
    foreach (vecs[k]) begin
      send_word(vecs[k].word, pulses, seen);
      check($sformatf("vec%0d pulses", k), W'(pulses), W'(vecs[k].exp_pulses));
      check($sformatf("vec%0d valid_o", k), W'(valid_o), W'(1));
      check($sformatf("vec%0d data_o", k), data_o, vecs[k].exp_data);
      check($sformatf("vec%0d overflow_o", k), W'(overflow_o), W'(0));
      idle();
      check($sformatf("vec%0d valid_o drop", k), W'(valid_o), W'(0));
    end

    // Back-to-back words with en held high.
    do_reset();
    ready_i = 1'b1;
    wa = WORD_A;
    wb = WORD_B;
    p0 = -1;
    p1 = -1;
    np = 0;
    da = '0;
    db = '0;
    for (int j = 0; j < 2 * W; j++) begin
      b = (j < W) ? wa[W-1-j] : wb[2*W-1-j];
      send_bit(b);
      if (valid_o) begin
        np++;
        if (np == 1) begin
          p0 = j;
          da = data_o;
        end else begin
          p1 = j;
          db = data_o;
        end
      end
    end
    idle();
    check("b2b pulse count", W'(np), W'(2));
    check("b2b first pulse", W'(p0), W'(127));
    check("b2b pulse spacing", W'(p1 - p0), W'(128));
    check("b2b word1", da, WORD_A);
    check("b2b word2", db, WORD_B);
    check("b2b overflow_o", W'(overflow_o), W'(0));

    // Backpressure across two full words.
    do_reset();
    ready_i = 1'b0;
    send_word(WORD_A, pulses, seen);
    send_word(WORD_B, pulses, seen);
    idle();
    check("bp valid_o", W'(valid_o), W'(1));
`ifdef SIPO_OVERFLOW_EN
    check("bp data_o", data_o, WORD_A);
    check("bp overflow_o", W'(overflow_o), W'(1));
`else
    check("bp data_o", data_o, WORD_B);
    check("bp overflow_o", W'(overflow_o), W'(0));
`endif
    // Flush must not disturb the held word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("bp hold valid_o", W'(valid_o), W'(1));
`ifdef SIPO_OVERFLOW_EN
    check("bp hold data_o", data_o, WORD_A);
    check("bp hold overflow_o", W'(overflow_o), W'(1));
`else
    check("bp hold data_o", data_o, WORD_B);
`endif
    ready_i = 1'b1;
    tick();
    check("bp drain valid_o", W'(valid_o), W'(0));

    // Flush after 60 bits of ones, then a word of 128'h1.
    do_reset();
    ready_i = 1'b1;
    for (int j = 0; j < 60; j++) send_bit(1'b1);
    flush  = 1'b1;
    en     = 1'b1;
    data_i = 1'b1;
    tick();
    flush = 1'b0;
    send_word(W'(1), pulses, seen);
    check("flush pulses", W'(pulses), W'(1));
    check("flush valid_o", W'(valid_o), W'(1));
    check("flush data_o", data_o, W'(1));
    idle();

    // Reset after 100 bits, then a full new word.
    wa = WORD_A;
    for (int j = 0; j < 100; j++) send_bit(wa[W-1-j]);
    rst = 1'b0;
    en  = 1'b0;
    #1;
    check("midreset data_o", data_o, W'(0));
    check("midreset valid_o", W'(valid_o), W'(0));
    tick();
    rst = 1'b1;
    send_word(WORD_B, pulses, seen);
    check("midreset pulses", W'(pulses), W'(1));
    check("midreset data_o new", seen, WORD_B);
    idle();

    // Completion on the same edge as a transfer of the prior word.
    do_reset();
    ready_i = 1'b0;
    send_word(WORD_A, pulses, seen);
    check("coinc first valid_o", W'(valid_o), W'(1));
    check("coinc first data_o", data_o, WORD_A);
    wb = WORD_B;
    for (int i = W - 1; i >= 1; i--) send_bit(wb[i]);
    check("coinc held data_o", data_o, WORD_A);
    ready_i = 1'b1;
    send_bit(wb[0]);
    check("coinc valid_o", W'(valid_o), W'(1));
    check("coinc data_o", data_o, WORD_B);
    check("coinc overflow_o", W'(overflow_o), W'(0));
    idle();
    check("coinc drain valid_o", W'(valid_o), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
